// File: rtl/multicycle_alu.sv
// Multicycle EX-stage ALU: single-cycle logic/arithmetic ops, iterative one-bit-per-cycle shifts
// behind a start/busy/done handshake.
module multicycle_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       ALUControl,
   input  logic             sral,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sh_reg, sh_next, result_reg, op_result;
   logic [SHW-1:0]   count, amt;
   logic             left, fill, is_shift, accept, accept_shift, done_reg;

   assign amt          = SrcB[SHW-1:0];
   assign is_shift     = (ALUControl == 3'b001) || (ALUControl == 3'b111);
   assign accept       = start && (state == IDLE);
   assign accept_shift = accept && is_shift && (amt != '0);

   // Shift codes only reach this path with a zero amount, which returns SrcA.
   always_comb begin
      op_result = SrcA;
      case (ALUControl)
         3'b000:  op_result = sral ? (SrcA - SrcB) : (SrcA + SrcB);
         3'b010:  op_result = SrcA & SrcB;
         3'b011:  op_result = SrcA | SrcB;
         3'b100:  op_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         3'b101:  op_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         3'b110:  op_result = SrcA ^ SrcB;
         default: op_result = SrcA;
      endcase
   end

   assign sh_next = left ? {sh_reg[WIDTH-2:0], 1'b0} : {fill, sh_reg[WIDTH-1:1]};

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept_shift) state_next = SHIFT;
         SHIFT:   if (count == SHW'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_reg <= '0;
         done_reg   <= 1'b0;
         sh_reg     <= '0;
         count      <= '0;
         left       <= 1'b0;
         fill       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (state == SHIFT) begin
            sh_reg <= sh_next;
            count  <= count - SHW'(1);
            if (count == SHW'(1)) begin
               result_reg <= sh_next;
               done_reg   <= 1'b1;
            end
         end else if (accept_shift) begin
            sh_reg <= SrcA;
            count  <= amt;
            left   <= (ALUControl == 3'b001);
            fill   <= (ALUControl == 3'b111) && !sral && SrcA[WIDTH-1];
         end else if (accept) begin
            result_reg <= op_result;
            done_reg   <= 1'b1;
         end
      end
   end

   assign ALUResult = result_reg;
   assign Zero      = (result_reg == '0);
   assign busy      = (state == SHIFT);
   assign done      = done_reg;

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Multicycle execute unit that consumes the `ALUControl`/`sral` encoding produced by the ALU decoder and computes the result. Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit position per cycle, to save area. It sits in the EX stage behind a start/busy/done handshake, and the hazard unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; must be a power of two ≥ 8
- `SHW`, `$clog2(WIDTH)` (derived, not overridden), shift-amount width

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `ALUControl`  in  3  operation code, sampled with `start`
- `sral`  in  1  sub/add and srl/sra modifier, sampled with `start`
- `SrcA`  in  WIDTH  operand A, sampled with `start`
- `SrcB`  in  WIDTH  operand B; shift amount is `SrcB[SHW-1:0]`
- `ALUResult`  out  WIDTH  registered result, held until the next completion
- `Zero`  out  1  `ALUResult == 0`, combinational from the result register
- `busy`  out  1  high while an iterative shift is in progress
- `done`  out  1  one-cycle pulse when `ALUResult` is updated

## Operation
Op decode, latched at accept:
- `000`: `sral`=0 add; `sral`=1 subtract (A−B)
- `001`: sll
- `010`: and
- `011`: or
- `100`: sltu (unsigned A<B → 1, else 0, zero-extended)
- `101`: slt (signed compare)
- `110`: xor
- `111`: shift right; `sral`=1 srl (zero fill); `sral`=0 sra (fill with latched `SrcA[WIDTH-1]`)

`sral` is ignored for codes other than `000` and `111`. Add and subtract wrap modulo 2^WIDTH, with no carry or overflow output.

State machine has two states: IDLE and SHIFT.
- IDLE, `start`=1, code not `001`/`111`, or shift amount = 0: compute at that edge, load `ALUResult`, set `done`, stay IDLE. A shift by 0 returns `SrcA` unchanged.
- IDLE, `start`=1, code `001`/`111`, amount N>0: load shift register with `SrcA`, load count=N, latch direction and fill bit, set `busy`, go to SHIFT.
- SHIFT: each edge shifts the register by 1 and decrements count. On the edge where count goes 1→0, it loads `ALUResult`, sets `done`, clears `busy` and returns to IDLE.
- `start` while `busy`=1 is ignored. No queuing; the operand inputs are don't-care.
- Back-to-back: `start` in the cycle where `done`=1 is accepted, because the unit is already IDLE.

## Timing
- Reset values: `ALUResult`=0, `Zero`=1, `busy`=0, `done`=0, state IDLE, count=0.
- Reset is taken at any time, including mid-shift. It aborts the operation with no `done` pulse, and outputs hold reset values from the next cycle.
- Latency, from the accepting edge to `done`=1 in the following cycle:
  - non-shift or N=0: 1 edge
  - shift by N: N+1 edges (load edge + N shift edges)
- `busy` is high from the cycle after acceptance until the cycle `done` rises. `busy` and `done` are never high together.
- `done` is high for exactly one cycle per accepted operation.
- `ALUResult` and `Zero` change only on a `done` edge or on reset.
- Maximum latency is WIDTH edges (N = WIDTH−1).

## Test plan
- Reset then idle → `ALUResult`=0, `Zero`=1, `busy`=0, `done`=0. Assert `start` mid-shift plus `reset` → no `done` pulse, outputs return to reset values.
- Code `000`, `sral`=1, A=5, B=5 → `done` 1 edge later, `ALUResult`=0, `Zero`=1. Repeat with `sral`=0, A=0xFFFFFFFF, B=1 → `ALUResult`=0 (wrap).
- Code `101`, A=0xFFFFFFFF, B=1 → `ALUResult`=1. Code `100` with the same operands → `ALUResult`=0.
- Code `111`, `sral`=0, A=0x80000000, B=4 → `busy` high 4 cycles, `done` on the 5th edge, `ALUResult`=0xF8000000. With `sral`=1 → 0x08000000.
- Code `001`, A=1, B=0x25 (shift amount 5) → `ALUResult`=0x20, latency 6. B=0 → `ALUResult`=1, latency 1. B=31 → `ALUResult`=0x80000000, latency 32.
- Hold `start` high with new operands during the shift → ignored. Issue `start` in the `done` cycle → accepted, second result correct, one `done` pulse per operation.
